neuron_mac_relu: RTL and testbench

- Single-neuron compute stage sitting directly downstream of one per-neuron weight ROM (16-bit, registered 1-cycle read, ren/radd interface).
- Accepts a stream of NUM_WEIGHT activations and drives the ROM's read port in lockstep.
- Multiply-accumulates, adds the neuron bias, rescales, saturates and applies ReLU.
- Emits one activation per input vector to the next layer.

---
 rtl/fnn_pkg.sv | 22 ++
 rtl/neuron_act_relu.sv | 41 ++++
 rtl/neuron_mac_relu.sv | 119 +++++++++++
 tb/tb_neuron_mac_relu.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fnn_pkg.sv
// Shared definitions for the feed-forward network compute stages.
//   state_t    : neuron sequencing states
//   DEF_*      : default fixed-point format
//   acc_width(): accumulator width that cannot overflow for a full dot product
package fnn_pkg;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        DRAIN  = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam int unsigned DEF_DATA_WIDTH = 16;
    localparam int unsigned DEF_FRAC_BITS  = 12;

    // Full-precision product width plus growth for num_weight additions.
    function automatic int unsigned acc_width(input int unsigned num_weight,
                                              input int unsigned data_width);
        return 2 * data_width + $clog2(num_weight);
    endfunction

endpackage

// File: rtl/neuron_act_relu.sv
// Combinational activation path: bias alignment, rescale, saturate, ReLU.
//   acc   : signed accumulated dot product (2*FRAC_BITS fractional bits)
//   bias  : signed neuron bias (FRAC_BITS fractional bits)
//   act_c : post-ReLU activation, saturated to DATA_WIDTH
module neuron_act_relu
    import fnn_pkg::*;
#(
    parameter int unsigned ACC_WIDTH  = 37,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned FRAC_BITS  = DEF_FRAC_BITS
)(
    input  logic [ACC_WIDTH-1:0]  acc,
    input  logic [DATA_WIDTH-1:0] bias,
    output logic [DATA_WIDTH-1:0] act_c
);

    // One guard bit so the bias addition itself cannot wrap.
    localparam int unsigned SUM_WIDTH = ACC_WIDTH + 1;

    logic [SUM_WIDTH-1:0] acc_ext;
    logic [SUM_WIDTH-1:0] bias_ext;
    logic [SUM_WIDTH-1:0] sum;
    logic [SUM_WIDTH-1:0] scaled;

    assign acc_ext  = {acc[ACC_WIDTH-1], acc};
    assign bias_ext = {{(SUM_WIDTH-DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias};
    assign sum      = acc_ext + (bias_ext << FRAC_BITS);
    // Arithmetic shift floors toward minus infinity.
    assign scaled   = SUM_WIDTH'($signed(sum) >>> FRAC_BITS);

    // Negative clamps to zero (ReLU subsumes the lower saturation bound).
    always_comb begin
        act_c = scaled[DATA_WIDTH-1:0];
        if (scaled[SUM_WIDTH-1]) begin
            act_c = '0;
        end else if (|scaled[SUM_WIDTH-2:DATA_WIDTH-1]) begin
            act_c = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    end

endmodule

// File: rtl/neuron_mac_relu.sv
// Single-neuron MAC + bias + rescale + ReLU stage fed by a registered weight ROM.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_data    : activation stream, in_ready back-pressure
//   bias                : signed bias, stable outside ACCUM
//   w_ren/w_radd/w_rdata: weight ROM read port (1-cycle registered read)
//   out_valid/out_data  : one-cycle result pulse, data held until next result
module neuron_mac_relu
    import fnn_pkg::*;
#(
    parameter int unsigned NUM_WEIGHT = 30,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned FRAC_BITS  = DEF_FRAC_BITS,
    parameter int unsigned ADDR_WIDTH = $clog2(NUM_WEIGHT)
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] bias,
    output logic                  w_ren,
    output logic [ADDR_WIDTH-1:0] w_radd,
    input  logic [DATA_WIDTH-1:0] w_rdata,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);

    localparam int unsigned ACC_WIDTH  = acc_width(NUM_WEIGHT, DATA_WIDTH);
    localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;

    state_t                 state;
    logic [ADDR_WIDTH-1:0]  cnt;
    logic                   drain_cnt;
    logic                   accept;

    logic [DATA_WIDTH-1:0]  x_d1;
    logic                   v_d1;
    logic [PROD_WIDTH-1:0]  prod;
    logic                   v_d2;
    logic [ACC_WIDTH-1:0]   acc;
    logic [DATA_WIDTH-1:0]  act_c;

    // ROM read is issued in the accept cycle so its data lines up with x_d1.
    assign in_ready = (state == ACCUM);
    assign accept   = in_valid & in_ready;
    assign w_ren    = accept;
    assign w_radd   = cnt;

    // Sequencer: count samples, drain the 3-stage pipe, then emit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACCUM;
            cnt       <= '0;
            drain_cnt <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                ACCUM: begin
                    if (accept) begin
                        if (cnt == ADDR_WIDTH'(NUM_WEIGHT - 1)) begin
                            cnt   <= '0;
                            state <= DRAIN;
                        end else begin
                            cnt <= cnt + ADDR_WIDTH'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt) begin
                        drain_cnt <= 1'b0;
                        state     <= FINISH;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                FINISH: begin
                    out_data  <= act_c;
                    out_valid <= 1'b1;
                    state     <= ACCUM;
                end
                default: state <= ACCUM;
            endcase
        end
    end

    // MAC pipeline: align sample with ROM data, multiply, accumulate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_d1 <= '0;
            v_d1 <= 1'b0;
            prod <= '0;
            v_d2 <= 1'b0;
            acc  <= '0;
        end else begin
            x_d1 <= in_data;
            v_d1 <= accept;
            prod <= PROD_WIDTH'($signed(x_d1)) * PROD_WIDTH'($signed(w_rdata));
            v_d2 <= v_d1;
            if (state == FINISH) begin
                acc <= '0;
            end else if (v_d2) begin
                acc <= acc + {{(ACC_WIDTH-PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};
            end
        end
    end

    neuron_act_relu #(
        .ACC_WIDTH  (ACC_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS)
    ) u_act (
        .acc   (acc),
        .bias  (bias),
        .act_c (act_c)
    );

endmodule

// File: tb/tb_neuron_mac_relu.sv
// Self-checking bench for neuron_mac_relu: directed and randomized vectors
// against a dot-product reference model, checked every cycle.
module tb_neuron_mac_relu;

    localparam int NW = 30;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic [15:0] bias = '0;
    logic [15:0] w_rdata = '0;
    logic        in_ready;
    logic        w_ren;
    logic [4:0]  w_radd;
    logic        out_valid;
    logic [15:0] out_data;

    always #5 clk = ~clk;

    neuron_mac_relu dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .bias      (bias),
        .w_ren     (w_ren),
        .w_radd    (w_radd),
        .w_rdata   (w_rdata),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    // Weight ROM with registered read.
    logic [15:0] weights [0:31];
    always @(posedge clk) if (w_ren) w_rdata <= weights[w_radd];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model state.
    int          cyc = 0;
    int          idx = 0;
    int          last_c = -100;
    int          wren_cnt = 0;
    int          ov_cnt = 0;
    logic signed [15:0] mx [0:NW-1];
    logic signed [15:0] mw [0:NW-1];
    logic [15:0] last_out = '0;
    typedef struct { int due; logic [15:0] val; } exp_t;
    exp_t        q[$];

    // Dot product + bias, floor-rescale, saturate, ReLU.
    function automatic logic [15:0] ref_neuron();
        longint s = 0;
        for (int i = 0; i < NW; i++) s += longint'(mx[i]) * longint'(mw[i]);
        s += longint'($signed(bias)) * 4096;
        s = s >>> 12;
        if (s < 0) return 16'h0000;
        if (s > 32767) return 16'h7FFF;
        return 16'(s);
    endfunction

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin : cmp
        bit er;
        bit ea;
        exp_t e;
        cyc++;
        if (rst) begin
            chk("rst_out_valid", out_valid, 1'b0);
            chk("rst_out_data", out_data, 16'h0);
            idx = 0;
            last_c = -100;
            last_out = '0;
            q.delete();
        end else begin
            er = !(cyc > last_c && cyc <= last_c + 3);
            chk("in_ready", in_ready, er);
            ea = in_valid && er;
            chk("w_ren", w_ren, ea);
            if (w_ren) wren_cnt++;
            if (ea) begin
                chk("w_radd", w_radd, idx);
                mx[idx] = in_data;
                mw[idx] = weights[idx];
                idx++;
                if (idx == NW) begin
                    e.due = cyc + 4;
                    e.val = ref_neuron();
                    q.push_back(e);
                    idx = 0;
                    last_c = cyc;
                end
            end
            if (q.size() > 0 && q[0].due == cyc) begin
                chk("out_valid", out_valid, 1'b1);
                chk("out_data", out_data, q[0].val);
                last_out = q[0].val;
                void'(q.pop_front());
            end else begin
                chk("out_valid_idle", out_valid, 1'b0);
                chk("out_data_hold", out_data, last_out);
            end
            if (out_valid) ov_cnt++;
        end
    end

    logic [15:0] vec [0:NW-1];

    // Present one sample, optionally after a bubble; hold until accepted.
    task automatic drive_sample(input logic [15:0] x, input int gap_pct);
        int t = 0;
        bit done = 0;
        if (int'($urandom_range(99)) < gap_pct) begin
            in_valid = 1'b0;
            in_data  = 16'($urandom);
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = x;
        while (!done) begin
            @(negedge clk);
            if (in_ready) done = 1;
            @(posedge clk);
            #1;
            t++;
            if (!done && t > 20) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout actual=stalled expected=accepted t=%0t", $time);
                done = 1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_vec(input int n, input int gap_pct);
        for (int i = 0; i < n; i++) drive_sample(vec[i], gap_pct);
    endtask

    task automatic fill(input logic [15:0] x, input logic [15:0] w);
        for (int i = 0; i < NW; i++) begin
            vec[i] = x;
            weights[i] = w;
        end
    endtask

    task automatic wait_idle();
        repeat (8) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) weights[i] = '0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_reset", in_ready, 1'b1);
        chk("data_after_reset", out_data, 16'h0);

        // Nominal.
        fill(16'h0100, 16'h1000);
        bias = 16'h0000;
        send_vec(NW, 0);
        wait_idle();
        chk("nominal", out_data, 16'h1E00);

        // Bias.
        bias = 16'h1000;
        send_vec(NW, 0);
        wait_idle();
        chk("bias_pos", out_data, 16'h2E00);
        bias = 16'hE000;
        send_vec(NW, 0);
        wait_idle();
        chk("bias_neg_relu", out_data, 16'h0000);

        // Saturation and negative sum.
        bias = 16'h0000;
        fill(16'h0800, 16'h1000);
        send_vec(NW, 0);
        wait_idle();
        chk("saturate", out_data, 16'h7FFF);
        fill(16'hF000, 16'h1000);
        send_vec(NW, 0);
        wait_idle();
        chk("negative_relu", out_data, 16'h0000);

        // Bubbles.
        fill(16'h0100, 16'h1000);
        wren_cnt = 0;
        send_vec(NW, 50);
        wait_idle();
        chk("gaps_result", out_data, 16'h1E00);
        chk("gaps_wren_count", wren_cnt, 30);

        // Back-to-back, second vector presented during drain.
        ov_cnt = 0;
        send_vec(NW, 0);
        fill(16'h0080, 16'h1000);
        send_vec(NW, 0);
        wait_idle();
        chk("b2b_second", out_data, 16'h0F00);
        chk("b2b_pulses", ov_cnt, 2);

        // Reset mid-vector.
        fill(16'h0100, 16'h1000);
        send_vec(NW, 0);
        wait_idle();
        send_vec(12, 0);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("midrst_out_data", out_data, 16'h0);
        chk("midrst_out_valid", out_valid, 1'b0);
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        ov_cnt = 0;
        send_vec(NW, 0);
        wait_idle();
        chk("after_midrst", out_data, 16'h1E00);
        chk("after_midrst_pulses", ov_cnt, 1);

        // Randomized vectors.
        for (int r = 0; r < 24; r++) begin
            bias = 16'(int'($urandom_range(0, 8191)) - 4096);
            for (int i = 0; i < NW; i++) begin
                if (r % 4 == 3) begin
                    vec[i]     = 16'($urandom);
                    weights[i] = 16'($urandom);
                end else begin
                    vec[i]     = 16'(int'($urandom_range(0, 2047)) - 1024);
                    weights[i] = 16'(int'($urandom_range(0, 16383)) - 8192);
                end
            end
            send_vec(NW, 30);
            if (r % 3 == 0) begin
                for (int i = 0; i < NW; i++) vec[i] = 16'(int'($urandom_range(0, 2047)) - 1024);
                send_vec(NW, 0);
            end
            wait_idle();
        end
        chk("queue_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
